// File: rtl/spi_pkg.sv
// Shared definitions for the SPI byte engine: command codes, FSM encoding, overflow bits.
package spi_pkg;

    localparam logic [1:0] RW_NONE  = 2'b00;
    localparam logic [1:0] RW_WRITE = 2'b01;
    localparam logic [1:0] RW_READ  = 2'b10;

    typedef enum logic [5:0] {
        StIdle  = 6'b000001,
        StSetup = 6'b000010,
        StLoad  = 6'b000100,
        StShift = 6'b001000,
        StHold  = 6'b010000,
        StGap   = 6'b100000
    } state_e;

    localparam int unsigned OVF_CMD = 0;
    localparam int unsigned OVF_RX  = 1;

endpackage

// File: rtl/spi_fifo.sv
// First-word-fall-through FIFO with a registered head; reads 0 when empty.
// Pushes while full are dropped, even when a pop happens in the same cycle.
module spi_fifo #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic [Width-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam logic [PtrW:0] FullCount = (PtrW + 1)'(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PtrW:0]    count_q, count_d;
    logic [Width-1:0] head_q, head_d;
    logic             push_ok, pop_ok;

    assign full_o  = (count_q == FullCount);
    assign empty_o = (count_q == '0);
    assign head_o  = head_q;

    always_comb begin
        push_ok  = push_i && !full_o;
        pop_ok   = pop_i && !empty_o;
        wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop_ok ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q + {{PtrW{1'b0}}, push_ok} - {{PtrW{1'b0}}, pop_ok};
        // The new head is the incoming word when nothing else remains ahead of it.
        if (count_d == '0) begin
            head_d = '0;
        end else if (push_ok && (rd_ptr_d == wr_ptr_q)) begin
            head_d = data_i;
        end else begin
            head_d = mem_q[rd_ptr_d];
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
        end
    end

endmodule

// File: rtl/spi_byte_engine.sv
// Byte-level mode-0 SPI master: queued write/read byte commands are shifted MSB-first inside
// one chip-select frame per burst; read bytes return through a FWFT receive FIFO.
module spi_byte_engine
    import spi_pkg::*;
#(
    parameter int unsigned CLK_DIV    = 4,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       command_read,
    input  logic [1:0] rw,
    input  logic       tx_read,
    input  logic [7:0] tx_byte,
    input  logic       rx_read,
    output logic [7:0] rx_byte,
    output logic       busy,
    output logic [1:0] ovf,
    output logic       spi_sclk,
    output logic       spi_mosi,
    input  logic       spi_miso,
    output logic       spi_cs_n
);
    localparam logic [7:0] DivLast = 8'(CLK_DIV - 1);

    state_e      state_q, state_d;
    logic [7:0]  div_q, div_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic        sclk_q, sclk_d;
    logic        mosi_q, mosi_d;
    logic        miso_bit_q, miso_bit_d;
    logic        is_read_q, is_read_d;
    logic        busy_q, busy_d;
    logic [1:0]  ovf_q, ovf_d;
    logic [1:0]  miso_sync_q;

    logic        cmd_push, cmd_pop, cmd_full, cmd_empty;
    logic [1:0]  cmd_head;
    logic        tx_pop, tx_full, tx_empty;
    logic [7:0]  tx_head;
    logic        rx_push, rx_pop, rx_full, rx_empty;
    logic [7:0]  rx_data;

    logic        div_done, load_go, last_fall;

    assign cmd_push = command_read && ((rw == RW_WRITE) || (rw == RW_READ));
    assign rx_pop   = rx_read && !rx_empty;
    assign rx_data  = {shift_q[6:0], miso_bit_q};

    spi_fifo #(.Width(2), .Depth(FIFO_DEPTH)) u_cmd_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .push_i (cmd_push),
        .data_i (rw),
        .pop_i  (cmd_pop),
        .head_o (cmd_head),
        .full_o (cmd_full),
        .empty_o(cmd_empty)
    );

    spi_fifo #(.Width(8), .Depth(FIFO_DEPTH)) u_tx_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .push_i (tx_read),
        .data_i (tx_byte),
        .pop_i  (tx_pop),
        .head_o (tx_head),
        .full_o (tx_full),
        .empty_o(tx_empty)
    );

    spi_fifo #(.Width(8), .Depth(FIFO_DEPTH)) u_rx_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .push_i (rx_push),
        .data_i (rx_data),
        .pop_i  (rx_pop),
        .head_o (rx_byte),
        .full_o (rx_full),
        .empty_o(rx_empty)
    );

    assign div_done  = (div_q == DivLast);
    assign load_go   = (state_q == StLoad) && !((cmd_head == RW_WRITE) && tx_empty);
    assign last_fall = (state_q == StShift) && div_done && sclk_q && (bit_cnt_q == 3'd7);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (!cmd_empty) state_d = StSetup;
            StSetup: if (div_done) state_d = StLoad;
            StLoad:  if (load_go) state_d = StShift;
            StShift: if (last_fall) state_d = cmd_empty ? StHold : StLoad;
            StHold:  if (div_done) state_d = StGap;
            StGap:   if (div_done) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        div_d      = '0;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        sclk_d     = sclk_q;
        mosi_d     = mosi_q;
        miso_bit_d = miso_bit_q;
        is_read_d  = is_read_q;
        cmd_pop    = 1'b0;
        tx_pop     = 1'b0;
        rx_push    = 1'b0;
        unique case (state_q)
            StSetup, StHold, StGap: begin
                div_d = div_done ? 8'd0 : div_q + 8'd1;
            end
            StLoad: begin
                bit_cnt_d = 3'd0;
                if (load_go) begin
                    cmd_pop   = 1'b1;
                    tx_pop    = (cmd_head == RW_WRITE);
                    is_read_d = (cmd_head == RW_READ);
                    shift_d   = (cmd_head == RW_WRITE) ? tx_head : 8'h00;
                    mosi_d    = (cmd_head == RW_WRITE) ? tx_head[7] : 1'b0;
                end
            end
            StShift: begin
                div_d = div_done ? 8'd0 : div_q + 8'd1;
                if (div_done) begin
                    sclk_d = !sclk_q;
                    if (!sclk_q) begin
                        miso_bit_d = miso_sync_q[1];
                    end else begin
                        // Falling edge: commit the sampled bit and present the next one.
                        shift_d   = rx_data;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        mosi_d    = (bit_cnt_q == 3'd7) ? 1'b0 : shift_q[6];
                        rx_push   = (bit_cnt_q == 3'd7) && is_read_q;
                    end
                end
            end
            default: ;
        endcase
    end

    assign busy_d = !cmd_empty || (state_q != StIdle);

    always_comb begin
        ovf_d = ovf_q;
        if ((cmd_push && cmd_full) || (tx_read && tx_full)) ovf_d[OVF_CMD] = 1'b1;
        if (rx_push && rx_full) ovf_d[OVF_RX] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q       <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            sclk_q      <= 1'b0;
            mosi_q      <= 1'b0;
            miso_bit_q  <= 1'b0;
            is_read_q   <= 1'b0;
            busy_q      <= 1'b0;
            ovf_q       <= '0;
            miso_sync_q <= '0;
        end else begin
            div_q       <= div_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            sclk_q      <= sclk_d;
            mosi_q      <= mosi_d;
            miso_bit_q  <= miso_bit_d;
            is_read_q   <= is_read_d;
            busy_q      <= busy_d;
            ovf_q       <= ovf_d;
            miso_sync_q <= {miso_sync_q[0], spi_miso};
        end
    end

    assign spi_cs_n = (state_q == StIdle) || (state_q == StGap);
    assign spi_sclk = sclk_q;
    assign spi_mosi = mosi_q;
    assign busy     = busy_q;
    assign ovf      = ovf_q;

endmodule

// File: tb/tb_spi_byte_engine.sv
// Self-checking bench for spi_byte_engine: a SPI slave model feeds MISO, a monitor records
// MOSI on SCLK rises, and a queue-based reference model predicts bytes, rx data and overflow.
module tb_spi_byte_engine;
    localparam int unsigned CLK_DIV    = 2;
    localparam int unsigned FIFO_DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       command_read = 1'b0;
    logic [1:0] rw = 2'b00;
    logic       tx_read = 1'b0;
    logic [7:0] tx_byte = 8'h00;
    logic       rx_read = 1'b0;
    logic [7:0] rx_byte;
    logic       busy;
    logic [1:0] ovf;
    logic       spi_sclk, spi_mosi, spi_cs_n;
    logic       spi_miso = 1'b0;

    int checks = 0;
    int errors = 0;

    spi_byte_engine #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .command_read(command_read),
        .rw          (rw),
        .tx_read     (tx_read),
        .tx_byte     (tx_byte),
        .rx_read     (rx_read),
        .rx_byte     (rx_byte),
        .busy        (busy),
        .ovf         (ovf),
        .spi_sclk    (spi_sclk),
        .spi_mosi    (spi_mosi),
        .spi_miso    (spi_miso),
        .spi_cs_n    (spi_cs_n)
    );

    always #5 clk = ~clk;

    // Monitor + slave. The slave presents its next bit right after each SCLK rise so the
    // value has settled through the master's input synchroniser before the next rise.
    int   rises = 0;
    int   cs_falls = 0;
    int   rise_cs_hi = 0;
    bit   mosi_bits[$];
    bit   slave_bits[$];
    logic sclk_prev = 1'b0;
    logic cs_prev = 1'b1;

    always @(negedge clk) begin
        if (sclk_prev === 1'b0 && spi_sclk === 1'b1) begin
            rises++;
            mosi_bits.push_back(spi_mosi);
            if (spi_cs_n !== 1'b0) rise_cs_hi++;
            if (slave_bits.size() > 0) void'(slave_bits.pop_front());
        end
        if (cs_prev === 1'b1 && spi_cs_n === 1'b0) cs_falls++;
        sclk_prev = spi_sclk;
        cs_prev   = spi_cs_n;
        spi_miso  = (slave_bits.size() > 0) ? slave_bits[0] : 1'b0;
    end

    // Reference model: each accepted command yields one byte on MOSI (tx byte or 0x00);
    // each read stores the slave byte unless the rx queue already holds FIFO_DEPTH bytes.
    logic [7:0] exp_mosi[$];
    logic [7:0] exp_rx[$];
    logic [1:0] exp_ovf = 2'b00;

    task automatic model_cmd(input bit is_read, input logic [7:0] txb, input logic [7:0] slv);
        exp_mosi.push_back(is_read ? 8'h00 : txb);
        if (is_read) begin
            if (exp_rx.size() < FIFO_DEPTH) exp_rx.push_back(slv);
            else exp_ovf[1] = 1'b1;
        end
        for (int i = 7; i >= 0; i--) slave_bits.push_back(slv[i]);
    endtask

    function automatic logic [7:0] mosi_byte(input int s);
        logic [7:0] b;
        for (int i = 0; i < 8; i++) b[7-i] = mosi_bits[s+i];
        return b;
    endfunction

    // Drives one cycle of inputs starting at a negedge; returns at the following negedge.
    task automatic drive_cmd(input logic [1:0] code, input bit push_tx, input logic [7:0] txb);
        command_read = (code != 2'b00);
        rw           = code;
        tx_read      = push_tx;
        tx_byte      = txb;
        @(negedge clk);
        command_read = 1'b0;
        rw           = 2'b00;
        tx_read      = 1'b0;
    endtask

    task automatic pulse_rx_read();
        rx_read = 1'b1;
        @(negedge clk);
        rx_read = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output bit ok, output logic [7:0] last_rx);
        int n;
        n = 0;
        last_rx = rx_byte;
        while (busy === 1'b1 && n < budget) begin
            last_rx = rx_byte;
            @(negedge clk);
            n++;
        end
        ok = (busy === 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        command_read = 1'b0; rw = 2'b00; tx_read = 1'b0; rx_read = 1'b0;
        slave_bits.delete();
        exp_rx.delete();
        exp_ovf = 2'b00;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (spi_cs_n !== 1'b1 || spi_sclk !== 1'b0 || spi_mosi !== 1'b0) begin
            errors++;
            $display("FAIL reset_spi: cs_n=%b sclk=%b mosi=%b expected 1 0 0",
                     spi_cs_n, spi_sclk, spi_mosi);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL reset_busy: got %b expected 0", busy);
        end
        checks++;
        if (rx_byte !== 8'h00 || ovf !== 2'b00) begin
            errors++;
            $display("FAIL reset_rx_ovf: rx_byte=%h ovf=%b expected 00 00", rx_byte, ovf);
        end
    endtask

    task automatic test_write_a5();
        int r0, m0, f0;
        bit ok;
        logic [7:0] last_rx;
        r0 = rises; m0 = mosi_bits.size(); f0 = cs_falls;
        exp_mosi.delete();
        model_cmd(1'b0, 8'hA5, 8'h00);
        drive_cmd(2'b01, 1'b1, 8'hA5);
        checks++;
        if (spi_cs_n !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL wr_n1: cs_n=%b busy=%b expected 1 0", spi_cs_n, busy);
        end
        @(negedge clk);
        checks++;
        if (spi_cs_n !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL wr_n2: cs_n=%b busy=%b expected 0 1", spi_cs_n, busy);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (spi_sclk !== 1'b0) begin
            errors++; $display("FAIL wr_sclk_n6: got %b expected 0", spi_sclk);
        end
        @(negedge clk);
        checks++;
        if (spi_sclk !== 1'b1) begin
            errors++; $display("FAIL wr_sclk_n7: got %b expected 1", spi_sclk);
        end
        wait_idle(1000, ok, last_rx);
        checks++;
        if (!ok) begin errors++; $display("FAIL wr_idle: busy=%b expected 0", busy); end
        checks++;
        if (rises - r0 != 8 || cs_falls - f0 != 1) begin
            errors++;
            $display("FAIL wr_edges: rises=%0d frames=%0d expected 8 1", rises - r0, cs_falls - f0);
        end
        checks++;
        if (mosi_byte(m0) !== exp_mosi[0]) begin
            errors++; $display("FAIL wr_mosi: got %h expected %h", mosi_byte(m0), exp_mosi[0]);
        end
        checks++;
        if (rx_byte !== 8'h00 || ovf !== exp_ovf) begin
            errors++;
            $display("FAIL wr_rx: rx_byte=%h ovf=%b expected 00 %b", rx_byte, ovf, exp_ovf);
        end
    endtask

    task automatic test_write_read();
        int r0, m0, f0;
        bit ok;
        logic [7:0] last_rx;
        r0 = rises; m0 = mosi_bits.size(); f0 = cs_falls;
        exp_mosi.delete();
        model_cmd(1'b0, 8'h8F, 8'h00);
        model_cmd(1'b1, 8'h00, 8'h3C);
        @(negedge clk);
        drive_cmd(2'b01, 1'b1, 8'h8F);
        drive_cmd(2'b10, 1'b0, 8'h00);
        @(negedge clk);
        wait_idle(1000, ok, last_rx);
        checks++;
        if (!ok) begin errors++; $display("FAIL wrrd_idle: busy=%b expected 0", busy); end
        checks++;
        if (rises - r0 != 16 || cs_falls - f0 != 1 || rise_cs_hi != 0) begin
            errors++;
            $display("FAIL wrrd_frame: rises=%0d frames=%0d rises_cs_high=%0d expected 16 1 0",
                     rises - r0, cs_falls - f0, rise_cs_hi);
        end
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (mosi_byte(m0 + 8 * i) !== exp_mosi[i]) begin
                errors++;
                $display("FAIL wrrd_mosi%0d: got %h expected %h", i, mosi_byte(m0 + 8 * i),
                         exp_mosi[i]);
            end
        end
        checks++;
        if (last_rx !== exp_rx[0]) begin
            errors++;
            $display("FAIL wrrd_rx_before_idle: got %h expected %h", last_rx, exp_rx[0]);
        end
        pulse_rx_read();
        void'(exp_rx.pop_front());
        checks++;
        if (rx_byte !== 8'h00) begin
            errors++; $display("FAIL wrrd_rx_pop: got %h expected 00", rx_byte);
        end
    endtask

    task automatic test_stall();
        int r0, m0, f0;
        bit ok;
        logic [7:0] last_rx;
        r0 = rises; m0 = mosi_bits.size(); f0 = cs_falls;
        exp_mosi.delete();
        model_cmd(1'b0, 8'h11, 8'h00);
        @(negedge clk);
        drive_cmd(2'b01, 1'b0, 8'h00);
        repeat (9) @(negedge clk);
        checks++;
        if (spi_cs_n !== 1'b0 || rises != r0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL stall_hold: cs_n=%b rises=%0d busy=%b expected 0 0 1",
                     spi_cs_n, rises - r0, busy);
        end
        drive_cmd(2'b00, 1'b1, 8'h11);
        wait_idle(1000, ok, last_rx);
        checks++;
        if (!ok || rises - r0 != 8 || cs_falls - f0 != 1) begin
            errors++;
            $display("FAIL stall_frame: idle=%b rises=%0d frames=%0d expected 1 8 1",
                     ok, rises - r0, cs_falls - f0);
        end
        checks++;
        if (mosi_byte(m0) !== exp_mosi[0]) begin
            errors++; $display("FAIL stall_mosi: got %h expected %h", mosi_byte(m0), exp_mosi[0]);
        end
    endtask

    task automatic test_rx_overflow();
        int r0;
        bit ok;
        logic [7:0] last_rx;
        r0 = rises;
        exp_mosi.delete();
        for (int i = 1; i <= 5; i++) model_cmd(1'b1, 8'h00, 8'(i));
        @(negedge clk);
        for (int i = 0; i < 4; i++) drive_cmd(2'b10, 1'b0, 8'h00);
        repeat (10) @(negedge clk);
        drive_cmd(2'b10, 1'b0, 8'h00);
        wait_idle(2000, ok, last_rx);
        checks++;
        if (!ok || rises - r0 != 40) begin
            errors++;
            $display("FAIL rxovf_frame: idle=%b rises=%0d expected 1 40", ok, rises - r0);
        end
        checks++;
        if (ovf !== exp_ovf) begin
            errors++; $display("FAIL rxovf_flag: got %b expected %b", ovf, exp_ovf);
        end
        while (exp_rx.size() > 0) begin
            checks++;
            if (rx_byte !== exp_rx[0]) begin
                errors++; $display("FAIL rxovf_pop: got %h expected %h", rx_byte, exp_rx[0]);
            end
            pulse_rx_read();
            void'(exp_rx.pop_front());
        end
        checks++;
        if (rx_byte !== 8'h00) begin
            errors++; $display("FAIL rxovf_empty: got %h expected 00", rx_byte);
        end
    endtask

    task automatic test_cmd_overflow();
        int r0;
        bit ok;
        logic [7:0] last_rx;
        do_reset();
        r0 = rises;
        exp_mosi.delete();
        // Only the first four fit; the fifth arrives while the cmd FIFO is full.
        for (int i = 0; i < 4; i++) model_cmd(1'b1, 8'h00, 8'($urandom_range(0, 255)));
        exp_ovf[0] = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 5; i++) drive_cmd(2'b10, 1'b0, 8'h00);
        wait_idle(2000, ok, last_rx);
        checks++;
        if (!ok || rises - r0 != 32) begin
            errors++;
            $display("FAIL cmdovf_bytes: idle=%b rises=%0d expected 1 32", ok, rises - r0);
        end
        checks++;
        if (ovf !== exp_ovf) begin
            errors++; $display("FAIL cmdovf_flag: got %b expected %b", ovf, exp_ovf);
        end
        while (exp_rx.size() > 0) begin
            checks++;
            if (rx_byte !== exp_rx[0]) begin
                errors++; $display("FAIL cmdovf_rx: got %h expected %h", rx_byte, exp_rx[0]);
            end
            pulse_rx_read();
            void'(exp_rx.pop_front());
        end
    endtask

    task automatic test_mid_reset();
        int r0, m0, f0, n;
        bit ok;
        logic [7:0] last_rx;
        do_reset();
        r0 = rises;
        @(negedge clk);
        drive_cmd(2'b01, 1'b1, 8'($urandom_range(0, 255)));
        n = 0;
        while (rises - r0 < 3 && n < 200) begin @(negedge clk); n++; end
        checks++;
        if (rises - r0 < 3) begin
            errors++; $display("FAIL midrst_start: rises=%0d expected 3", rises - r0);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (spi_cs_n !== 1'b1 || spi_sclk !== 1'b0 || busy !== 1'b0 || spi_mosi !== 1'b0) begin
            errors++;
            $display("FAIL midrst_outputs: cs_n=%b sclk=%b busy=%b mosi=%b expected 1 0 0 0",
                     spi_cs_n, spi_sclk, busy, spi_mosi);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        r0 = rises; m0 = mosi_bits.size(); f0 = cs_falls;
        exp_mosi.delete();
        model_cmd(1'b0, 8'h5A, 8'h00);
        drive_cmd(2'b01, 1'b1, 8'h5A);
        @(negedge clk);
        wait_idle(1000, ok, last_rx);
        checks++;
        if (!ok || rises - r0 != 8 || cs_falls - f0 != 1) begin
            errors++;
            $display("FAIL midrst_frame: idle=%b rises=%0d frames=%0d expected 1 8 1",
                     ok, rises - r0, cs_falls - f0);
        end
        checks++;
        if (mosi_byte(m0) !== exp_mosi[0]) begin
            errors++; $display("FAIL midrst_mosi: got %h expected %h", mosi_byte(m0), exp_mosi[0]);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int it = 0; it < 4; it++) begin
            int r0, m0, f0, k;
            bit ok, is_rd;
            logic [7:0] last_rx, txb, slv;
            r0 = rises; m0 = mosi_bits.size(); f0 = cs_falls;
            exp_mosi.delete();
            k = $urandom_range(1, 3);
            @(negedge clk);
            for (int c = 0; c < k; c++) begin
                is_rd = 1'($urandom_range(0, 1));
                txb   = 8'($urandom_range(0, 255));
                slv   = 8'($urandom_range(0, 255));
                model_cmd(is_rd, txb, slv);
                drive_cmd(is_rd ? 2'b10 : 2'b01, !is_rd, txb);
            end
            @(negedge clk);
            wait_idle(2000, ok, last_rx);
            checks++;
            if (!ok || rises - r0 != 8 * k || cs_falls - f0 != 1) begin
                errors++;
                $display("FAIL b2b_frame%0d: idle=%b rises=%0d frames=%0d expected 1 %0d 1",
                         it, ok, rises - r0, cs_falls - f0, 8 * k);
            end
            for (int c = 0; c < k; c++) begin
                checks++;
                if (mosi_byte(m0 + 8 * c) !== exp_mosi[c]) begin
                    errors++;
                    $display("FAIL b2b_mosi%0d_%0d: got %h expected %h", it, c,
                             mosi_byte(m0 + 8 * c), exp_mosi[c]);
                end
            end
            while (exp_rx.size() > 0) begin
                checks++;
                if (rx_byte !== exp_rx[0]) begin
                    errors++;
                    $display("FAIL b2b_rx%0d: got %h expected %h", it, rx_byte, exp_rx[0]);
                end
                pulse_rx_read();
                void'(exp_rx.pop_front());
            end
        end
        checks++;
        if (ovf !== exp_ovf || rx_byte !== 8'h00) begin
            errors++;
            $display("FAIL b2b_end: ovf=%b rx_byte=%h expected %b 00", ovf, rx_byte, exp_ovf);
        end
    endtask

    initial begin
        test_reset();
        test_write_a5();
        test_write_read();
        test_stall();
        test_rx_overflow();
        test_cmd_overflow();
        test_mid_reset();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
